// File: rtl/iob_fifo_reader.sv
// rtl/iob_fifo_reader.sv - FIFO read-port drain engine with 2-entry skid buffer and frame marker
// Issues reads against a registered-empty sync FIFO and streams words out on valid/ready.

module iob_fifo_reader #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              cke_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic [LEN_W-1:0]  len_i,
   output logic              fifo_r_en_o,
   input  logic [DATA_W-1:0] fifo_r_data_i,
   input  logic              fifo_empty_i,
   output logic [DATA_W-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              last_o,
   output logic [LEN_W-1:0]  beat_cnt_o
);

   logic [DATA_W-1:0] buf0_q, buf0_d;
   logic [DATA_W-1:0] buf1_q, buf1_d;
   logic              head_q, head_d;
   logic              tail_q, tail_d;
   logic [1:0]        occ_q, occ_d;
   logic              inflight_q, inflight_d;
   logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;

   logic              pop;
   logic              frame_end;
   logic [2:0]        credit;

   assign valid_o    = (occ_q != 2'd0);
   assign data_o     = head_q ? buf1_q : buf0_q;
   assign pop        = valid_o & ready_i;
   // occupancy after this cycle; a read may only be issued if its word will have a slot
   assign credit     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign fifo_r_en_o = cke_i & ~arst_i & en_i & ~fifo_empty_i & ~rst_i & (credit < 3'd2);
   assign frame_end  = (len_i != '0) && (beat_cnt_q == len_i - LEN_W'(1));
   assign last_o     = valid_o & frame_end;
   assign beat_cnt_o = beat_cnt_q;

   always_comb begin
      buf0_d     = buf0_q;
      buf1_d     = buf1_q;
      head_d     = head_q;
      tail_d     = tail_q;
      occ_d      = occ_q;
      inflight_d = inflight_q;
      beat_cnt_d = beat_cnt_q;
      if (cke_i) begin
         if (rst_i) begin
            head_d     = 1'b0;
            tail_d     = 1'b0;
            occ_d      = 2'd0;
            inflight_d = 1'b0;
            beat_cnt_d = '0;
         end else begin
            inflight_d = fifo_r_en_o;
            if (inflight_q) begin
               if (tail_q) buf1_d = fifo_r_data_i;
               else        buf0_d = fifo_r_data_i;
               tail_d = ~tail_q;
            end
            if (pop) begin
               head_d     = ~head_q;
               beat_cnt_d = frame_end ? '0 : beat_cnt_q + LEN_W'(1);
            end
            occ_d = credit[1:0];
         end
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         buf0_q     <= '0;
         buf1_q     <= '0;
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         occ_q      <= 2'd0;
         inflight_q <= 1'b0;
         beat_cnt_q <= '0;
      end else begin
         buf0_q     <= buf0_d;
         buf1_q     <= buf1_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         occ_q      <= occ_d;
         inflight_q <= inflight_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

endmodule

// File: tb/tb_iob_fifo_reader.sv
// tb/tb_iob_fifo_reader.sv - scoreboard bench for iob_fifo_reader
// Stimulus pushes expected {last,data} into a queue; a negedge monitor pops on every accepted beat.

module tb_iob_fifo_reader;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        cke = 1'b1;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [15:0] len = 16'd0;
   logic        fifo_r_en;
   logic [31:0] f_rdata = 32'd0;
   logic        f_empty = 1'b1;
   logic [31:0] data_o;
   logic        valid_o;
   logic        ready = 1'b0;
   logic        last_o;
   logic [15:0] beat_cnt;

   logic        wr_en = 1'b0;
   logic [31:0] wr_data = 32'd0;
   logic        fifo_clr = 1'b0;
   logic [31:0] fifo_q[$];
   logic [32:0] exp_q[$];
   int          rd_cyc_q[$];
   int          pop_cyc_q[$];
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   iob_fifo_reader #(.DATA_W(32), .LEN_W(16)) dut (
      .clk_i         (clk),
      .arst_i        (arst),
      .cke_i         (cke),
      .rst_i         (rst),
      .en_i          (en),
      .len_i         (len),
      .fifo_r_en_o   (fifo_r_en),
      .fifo_r_data_i (f_rdata),
      .fifo_empty_i  (f_empty),
      .data_o        (data_o),
      .valid_o       (valid_o),
      .ready_i       (ready),
      .last_o        (last_o),
      .beat_cnt_o    (beat_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // sync FIFO model: registered empty flag, read data one cycle after r_en
   always @(posedge clk) begin
      if (fifo_clr) begin
         fifo_q.delete();
         f_empty <= 1'b1;
      end else begin
         if (fifo_r_en) begin
            total++;
            if (fifo_q.size() == 0) begin
               bad++;
               $display("FAIL fifo_underflow act=read_on_empty exp=no_read cyc=%0d", cyc);
            end else begin
               f_rdata <= fifo_q.pop_front();
            end
         end
         if (wr_en) fifo_q.push_back(wr_data);
         f_empty <= (fifo_q.size() == 0);
      end
   end

   always @(negedge clk) begin
      logic [32:0] e;
      if (fifo_r_en) rd_cyc_q.push_back(cyc);
      if (valid_o && ready) begin
         pop_cyc_q.push_back(cyc);
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected act=%h last=%b exp=none", data_o, last_o);
         end else begin
            e = exp_q.pop_front();
            if ({last_o, data_o} !== e)  begin
               bad++;
               $display("FAIL sb_word act=%h last=%b exp=%h last=%b", data_o, last_o, e[31:0], e[32]);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic fifo_write(input logic [31:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      tick();
      wr_en   = 1'b0;
   endtask

   task automatic expect_word(input logic [31:0] d, input logic lst);
      exp_q.push_back({lst, d});
   endtask

   task automatic push_word(input logic [31:0] d, input logic lst);
      expect_word(d, lst);
      fifo_write(d);
   endtask

   task automatic clear_logs();
      rd_cyc_q.delete();
      pop_cyc_q.delete();
   endtask

   task automatic wait_drain(input int n, input logic rnd);
      int k = 0;
      while (exp_q.size() != 0 && k < n) begin
         if (rnd) ready = 1'($urandom_range(0, 1));
         tick();
         k++;
      end
      ready = 1'b1;
      tick();
      chk("drain_done", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_data", 64'(data_o), 64'd0);
      chk("rst_last", 64'(last_o), 64'd0);
      chk("rst_beat", 64'(beat_cnt), 64'd0);
      chk("rst_rd_en", 64'(fifo_r_en), 64'd0);
      arst = 1'b0;
      tick();

      // basic drain
      clear_logs();
      en = 1'b1;
      ready = 1'b1;
      push_word(32'h11, 1'b0);
      push_word(32'h22, 1'b0);
      push_word(32'h33, 1'b0);
      wait_drain(20, 1'b0);
      chk("basic_rd_cnt", 64'(rd_cyc_q.size()), 64'd3);
      chk("basic_rd_consec", 64'(rd_cyc_q[2] - rd_cyc_q[0]), 64'd2);
      chk("basic_pop_cnt", 64'(pop_cyc_q.size()), 64'd3);
      chk("basic_latency", 64'(pop_cyc_q[0] - rd_cyc_q[0]), 64'd2);
      chk("basic_pop_consec", 64'(pop_cyc_q[2] - pop_cyc_q[0]), 64'd2);

      // backpressure
      clear_logs();
      ready = 1'b0;
      for (int i = 0; i < 8; i++) push_word(32'hA0 + 32'(i), 1'b0);
      repeat (6) tick();
      chk("bp_rd_cnt", 64'(rd_cyc_q.size()), 64'd2);
      chk("bp_valid", 64'(valid_o), 64'd1);
      chk("bp_head", 64'(data_o), 64'hA0);
      repeat (3) tick();
      chk("bp_head_stable", 64'(data_o), 64'hA0);
      chk("bp_rd_cnt_hold", 64'(rd_cyc_q.size()), 64'd2);
      ready = 1'b1;
      wait_drain(30, 1'b0);
      chk("bp_pop_cnt", 64'(pop_cyc_q.size()), 64'd8);
      chk("bp_no_gaps", 64'(pop_cyc_q[7] - pop_cyc_q[0]), 64'd7);
      chk("bp_resume_same_cycle", 64'(rd_cyc_q[2]), 64'(pop_cyc_q[0]));
      chk("bp_beat_unframed", 64'(beat_cnt), 64'd11);

      // framing, len=3 then unframed
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("frame_flush_beat", 64'(beat_cnt), 64'd0);
      len = 16'd3;
      ready = 1'b0;
      for (int i = 0; i < 7; i++) push_word(32'hF0 + 32'(i), (i == 2 || i == 5));
      wait_drain(200, 1'b1);
      chk("frame_beat_after7", 64'(beat_cnt), 64'd1);
      len = 16'd0;
      ready = 1'b0;
      for (int i = 0; i < 4; i++) push_word(32'hE0 + 32'(i), 1'b0);
      wait_drain(200, 1'b1);
      chk("unframed_beat", 64'(beat_cnt), 64'd5);

      // enable gating
      clear_logs();
      en = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < 4; i++) fifo_write(32'hB0 + 32'(i));
      repeat (2) tick();
      chk("gate_no_rd", 64'(rd_cyc_q.size()), 64'd0);
      expect_word(32'hB0, 1'b0);
      en = 1'b1;
      tick();
      en = 1'b0;
      repeat (6) tick();
      chk("gate_rd_cnt", 64'(rd_cyc_q.size()), 64'd1);
      chk("gate_pop_cnt", 64'(pop_cyc_q.size()), 64'd1);
      chk("gate_fifo_not_empty", 64'(f_empty), 64'd0);
      chk("gate_fifo_left", 64'(fifo_q.size()), 64'd3);

      // flush with buffered and in-flight words
      clear_logs();
      ready = 1'b0;
      en = 1'b1;
      repeat (4) tick();
      chk("flush_pre_valid", 64'(valid_o), 64'd1);
      chk("flush_pre_head", 64'(data_o), 64'hB1);
      expect_word(32'hB1, 1'b0);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("flush_valid", 64'(valid_o), 64'd0);
      chk("flush_beat", 64'(beat_cnt), 64'd0);
      push_word(32'hB4, 1'b0);
      ready = 1'b1;
      wait_drain(20, 1'b0);
      chk("flush_pop_cnt", 64'(pop_cyc_q.size()), 64'd2);
      chk("flush_rd_cnt", 64'(rd_cyc_q.size()), 64'd4);

      // async reset mid-stream
      ready = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 6; i++) push_word(32'hC0 + 32'(i), 1'b0);
      chk("arst_streaming", 64'(valid_o), 64'd1);
      #1;
      arst = 1'b1;
      #1;
      chk("arst_valid", 64'(valid_o), 64'd0);
      chk("arst_data", 64'(data_o), 64'd0);
      chk("arst_last", 64'(last_o), 64'd0);
      chk("arst_beat", 64'(beat_cnt), 64'd0);
      chk("arst_rd_en", 64'(fifo_r_en), 64'd0);
      exp_q.delete();
      fifo_clr = 1'b1;
      tick();
      fifo_clr = 1'b0;
      tick();
      arst = 1'b0;
      repeat (3) tick();
      chk("post_arst_idle", 64'(valid_o), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
